// File: rtl/lfsr_sequence_checker_if.sv
// Link between an LFSR source and its sequence checker.
// LFSR_CHECKER_WRAP_EN adds the seed-wrap pulse and counter signals.
interface lfsr_sequence_checker_if #(parameter int ERR_W = 16);
  logic             in_valid;
  logic [3:0]       in_word;
  logic             clear_errors;
  logic             locked;
  logic             err_pulse;
  logic             zero_seen;
  logic [ERR_W-1:0] err_count;
`ifdef LFSR_CHECKER_WRAP_EN
  logic             wrap_pulse;
  logic [7:0]       wrap_count;

  modport master (output in_valid, in_word, clear_errors,
                  input  locked, err_pulse, zero_seen, err_count, wrap_pulse, wrap_count);
  modport slave  (input  in_valid, in_word, clear_errors,
                  output locked, err_pulse, zero_seen, err_count, wrap_pulse, wrap_count);
`else
  modport master (output in_valid, in_word, clear_errors,
                  input  locked, err_pulse, zero_seen, err_count);
  modport slave  (input  in_valid, in_word, clear_errors,
                  output locked, err_pulse, zero_seen, err_count);
`endif
endinterface

// File: rtl/lfsr_sequence_checker.sv
// Locks onto a 4-bit x^4+x^3+1 LFSR word stream, then flags and counts mispredictions.
// Optional LFSR_CHECKER_WRAP_EN: pulse/count each matched seed word while locked.
module lfsr_sequence_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_W      = 16
) (
  input  logic clock,
  input  logic reset,
  lfsr_sequence_checker_if.slave bus
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  localparam logic [3:0] SEED = 4'b0111;

  // bit 3 is w[1], bit 0 is w[4]
  function automatic logic [3:0] lfsr_next(input logic [3:0] w);
    return {w[1] ^ w[0], w[3:1]};
  endfunction

  state_t        state, state_nx;
  logic [3:0]    pred, pred_nx;
  logic [GW-1:0] good_cnt, good_nx;
  logic [BW-1:0] bad_cnt, bad_nx;
  logic          err_nx, zero_nx, inc, match;
`ifdef LFSR_CHECKER_WRAP_EN
  logic          wrap_nx;
`endif

  assign match = (bus.in_word == pred);

  always_comb begin
    state_nx = state;
    pred_nx  = pred;
    good_nx  = good_cnt;
    bad_nx   = bad_cnt;
    err_nx   = 1'b0;
    zero_nx  = 1'b0;
    inc      = 1'b0;
`ifdef LFSR_CHECKER_WRAP_EN
    wrap_nx  = 1'b0;
`endif
    if (bus.in_valid) begin
      if (bus.in_word == 4'b0000) begin
        // all-zero is outside the cycle: restart the hunt, never counted as an error
        zero_nx  = 1'b1;
        state_nx = HUNT;
      end else begin
        case (state)
          HUNT: begin
            pred_nx  = lfsr_next(bus.in_word);
            good_nx  = '0;
            bad_nx   = '0;
            state_nx = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
          end
          VERIFY: begin
            pred_nx = lfsr_next(bus.in_word);
            if (!match) begin
              good_nx = '0;
            end else if (good_cnt == GW'(LOCK_COUNT - 1)) begin
              state_nx = LOCKED;
              bad_nx   = '0;
            end else begin
              good_nx = good_cnt + GW'(1);
            end
          end
          LOCKED: begin
            // flywheel on our own prediction; a bad word never reseeds
            pred_nx = lfsr_next(pred);
            if (match) begin
              bad_nx = '0;
`ifdef LFSR_CHECKER_WRAP_EN
              wrap_nx = (bus.in_word == SEED);
`endif
            end else begin
              err_nx = 1'b1;
              inc    = 1'b1;
              if (bad_cnt == BW'(LOSS_COUNT - 1)) state_nx = HUNT;
              else                                bad_nx   = bad_cnt + BW'(1);
            end
          end
          default: state_nx = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= HUNT;
      pred          <= SEED;
      good_cnt      <= '0;
      bad_cnt       <= '0;
      bus.locked    <= 1'b0;
      bus.err_pulse <= 1'b0;
      bus.zero_seen <= 1'b0;
      bus.err_count <= '0;
    end else begin
      state         <= state_nx;
      pred          <= pred_nx;
      good_cnt      <= good_nx;
      bad_cnt       <= bad_nx;
      bus.locked    <= (state_nx == LOCKED);
      bus.err_pulse <= err_nx;
      bus.zero_seen <= zero_nx;
      // clear wins over a same-cycle increment
      if (bus.clear_errors)                 bus.err_count <= '0;
      else if (inc && (bus.err_count != '1)) bus.err_count <= bus.err_count + ERR_W'(1);
    end
  end

`ifdef LFSR_CHECKER_WRAP_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.wrap_pulse <= 1'b0;
      bus.wrap_count <= '0;
    end else begin
      bus.wrap_pulse <= wrap_nx;
      if (wrap_nx) bus.wrap_count <= bus.wrap_count + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Bench: default checker plus a small one (ERR_W=2, LOSS_COUNT=8), both fed the same stream
// and compared against a table-driven model of the legal LFSR cycle.
module tb_lfsr_sequence_checker;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  lfsr_sequence_checker_if #(.ERR_W(16)) dif();
  lfsr_sequence_checker_if #(.ERR_W(2))  sif();

  lfsr_sequence_checker #(.LOCK_COUNT(3), .LOSS_COUNT(2), .ERR_W(16)) u_def (
    .clock(clock), .reset(reset), .bus(dif.slave));
  lfsr_sequence_checker #(.LOCK_COUNT(3), .LOSS_COUNT(8), .ERR_W(2)) u_small (
    .clock(clock), .reset(reset), .bus(sif.slave));

  logic [3:0] seq [15] = '{4'b0111, 4'b0011, 4'b0001, 4'b1000, 4'b0100,
                           4'b0010, 4'b1001, 4'b1100, 4'b0110, 4'b1011,
                           4'b0101, 4'b1010, 4'b1101, 4'b1110, 4'b1111};

  typedef struct {
    int mode;   // 0 hunt, 1 verify, 2 locked
    int pidx;   // index of predicted word in seq
    int good;
    int bad;
    bit errp;
    bit zero;
    int errc;
    bit wrapp;
    int wrapc;
  } mdl_t;

  mdl_t md, ms;
  int checks = 0;
  int failures = 0;

  function automatic int idx_of(input logic [3:0] w);
    for (int i = 0; i < 15; i++) if (seq[i] == w) return i;
    return -1;
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m.mode = 0; m.pidx = 0; m.good = 0; m.bad = 0; m.errp = 0;
    m.zero = 0; m.errc = 0; m.wrapp = 0; m.wrapc = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit v, input logic [3:0] w, input bit clr,
                                 input int lockc, input int lossc, input int emax);
    mdl_t n = m;
    int i;
    n.errp = 0; n.zero = 0; n.wrapp = 0;
    if (clr) n.errc = 0;
    if (!v) return n;
    if (w == 4'b0000) begin n.zero = 1; n.mode = 0; return n; end
    i = idx_of(w);
    if (m.mode == 0) begin
      n.pidx = (i + 1) % 15; n.good = 0; n.bad = 0;
      n.mode = (lockc == 1) ? 2 : 1;
    end else if (m.mode == 1) begin
      n.pidx = (i + 1) % 15;
      if (i == m.pidx) begin
        n.good = m.good + 1;
        if (n.good == lockc) begin n.mode = 2; n.bad = 0; end
      end else n.good = 0;
    end else begin
      n.pidx = (m.pidx + 1) % 15;
      if (i == m.pidx) begin
        n.bad = 0;
        if (i == 0) begin n.wrapp = 1; n.wrapc = (m.wrapc + 1) % 256; end
      end else begin
        n.errp = 1;
        if (!clr && n.errc < emax) n.errc = n.errc + 1;
        n.bad = m.bad + 1;
        if (n.bad == lossc) n.mode = 0;
      end
    end
    return n;
  endfunction

  // one clock: drive at negedge, models advance at posedge, caller samples 1 ns later
  task automatic step(input bit rst, input bit v, input logic [3:0] w, input bit clr);
    @(negedge clock);
    reset = rst;
    dif.in_valid = v; dif.in_word = w; dif.clear_errors = clr;
    sif.in_valid = v; sif.in_word = w; sif.clear_errors = clr;
    @(posedge clock);
    if (rst) begin md = mreset(); ms = mreset(); end
    else begin
      md = mstep(md, v, w, clr, 3, 2, 65535);
      ms = mstep(ms, v, w, clr, 3, 8, 3);
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 4'b0101, 1);
    step(1, 0, 4'b0000, 0);
    checks++;
    if (dif.locked !== 1'b0 || dif.err_pulse !== 1'b0 || dif.zero_seen !== 1'b0 || dif.err_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_def: locked=%b err=%b zero=%b cnt=%0d, want all 0", dif.locked, dif.err_pulse, dif.zero_seen, dif.err_count);
    end
    checks++;
    if (sif.locked !== 1'b0 || sif.err_count !== 2'd0) begin
      failures++;
      $display("FAIL reset_small: locked=%b cnt=%0d, want 0 0", sif.locked, sif.err_count);
    end
`ifdef LFSR_CHECKER_WRAP_EN
    checks++;
    if (dif.wrap_pulse !== 1'b0 || dif.wrap_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_wrap: pulse=%b count=%0d, want 0 0", dif.wrap_pulse, dif.wrap_count);
    end
`endif
  endtask

  task automatic test_lock();
    bit want [4] = '{0, 0, 0, 1};
    for (int k = 0; k < 4; k++) begin
      step(0, 1, seq[k], 0);
      checks++;
      if (dif.locked !== want[k]) begin
        failures++;
        $display("FAIL lock_word%0d: locked=%b want=%b", k, dif.locked, want[k]);
      end
    end
    checks++;
    if (dif.err_count !== 16'd0) begin
      failures++;
      $display("FAIL lock_errcnt: got=%0d want=0", dif.err_count);
    end
  endtask

  task automatic test_single_error();
    step(0, 1, 4'b0101, 0);
    checks++;
    if (dif.err_pulse !== 1'b1 || dif.err_count !== 16'd1 || dif.locked !== 1'b1) begin
      failures++;
      $display("FAIL single_err: pulse=%b cnt=%0d locked=%b want 1 1 1", dif.err_pulse, dif.err_count, dif.locked);
    end
    step(0, 1, 4'b0010, 0);
    checks++;
    if (dif.err_pulse !== 1'b0 || dif.err_count !== 16'd1 || dif.locked !== 1'b1) begin
      failures++;
      $display("FAIL flywheel_match: pulse=%b cnt=%0d locked=%b want 0 1 1", dif.err_pulse, dif.err_count, dif.locked);
    end
  endtask

  task automatic test_loss_relock();
    step(0, 1, 4'b0001, 0);
    checks++;
    if (dif.err_count !== 16'd2 || dif.locked !== 1'b1) begin
      failures++;
      $display("FAIL loss_first: cnt=%0d locked=%b want 2 1", dif.err_count, dif.locked);
    end
    step(0, 1, 4'b0001, 0);
    checks++;
    if (dif.err_count !== 16'd3 || dif.locked !== 1'b0) begin
      failures++;
      $display("FAIL loss_second: cnt=%0d locked=%b want 3 0", dif.err_count, dif.locked);
    end
    checks++;
    if (sif.locked !== 1'b1 || sif.err_count !== 2'd3) begin
      failures++;
      $display("FAIL loss_small: locked=%b cnt=%0d want 1 3", sif.locked, sif.err_count);
    end
    for (int k = 7; k <= 10; k++) begin
      step(0, 1, seq[k], 0);
      checks++;
      if (dif.locked !== (k == 10)) begin
        failures++;
        $display("FAIL relock_word%0d: locked=%b want=%b", k, dif.locked, k == 10);
      end
    end
  endtask

  task automatic test_zero_gap();
    step(0, 0, 4'b1111, 0);
    step(0, 0, 4'b0000, 0);
    step(0, 1, seq[11], 0);
    step(0, 0, 4'b0011, 0);
    step(0, 1, seq[12], 0);
    checks++;
    if (dif.locked !== 1'b1 || dif.err_count !== 16'd3 || dif.err_pulse !== 1'b0) begin
      failures++;
      $display("FAIL gap_hold: locked=%b cnt=%0d pulse=%b want 1 3 0", dif.locked, dif.err_count, dif.err_pulse);
    end
    step(0, 1, 4'b0000, 0);
    checks++;
    if (dif.zero_seen !== 1'b1 || dif.locked !== 1'b0 || dif.err_count !== 16'd3 || dif.err_pulse !== 1'b0) begin
      failures++;
      $display("FAIL zero_locked: zero=%b locked=%b cnt=%0d pulse=%b want 1 0 3 0", dif.zero_seen, dif.locked, dif.err_count, dif.err_pulse);
    end
    step(0, 0, 4'b0000, 0);
    checks++;
    if (dif.zero_seen !== 1'b0) begin
      failures++;
      $display("FAIL zero_one_cycle: zero=%b want 0", dif.zero_seen);
    end
  endtask

  task automatic test_saturate_clear();
    int p = 4;
    int sw [5] = '{1, 2, 3, 3, 3};
    step(1, 0, 4'b0000, 0);
    for (int k = 0; k < 4; k++) step(0, 1, seq[k], 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, seq[(p + 5) % 15], 0);
      p = (p + 1) % 15;
      checks++;
      if (sif.err_count !== 2'(sw[k]) || sif.err_pulse !== 1'b1 || sif.locked !== 1'b1) begin
        failures++;
        $display("FAIL sat_err%0d: cnt=%0d pulse=%b locked=%b want %0d 1 1", k, sif.err_count, sif.err_pulse, sif.locked, sw[k]);
      end
      checks++;
      if (dif.err_count !== 16'(k + 1) || dif.locked !== 1'b1) begin
        failures++;
        $display("FAIL isolated_err%0d: cnt=%0d locked=%b want %0d 1", k, dif.err_count, dif.locked, k + 1);
      end
      step(0, 1, seq[p], 0);
      p = (p + 1) % 15;
    end
    step(0, 1, seq[(p + 5) % 15], 1);
    checks++;
    if (sif.err_count !== 2'd0 || sif.err_pulse !== 1'b1 || dif.err_count !== 16'd0 || dif.err_pulse !== 1'b1) begin
      failures++;
      $display("FAIL clear_vs_inc: small cnt=%0d pulse=%b def cnt=%0d pulse=%b want 0 1 0 1", sif.err_count, sif.err_pulse, dif.err_count, dif.err_pulse);
    end
  endtask

`ifdef LFSR_CHECKER_WRAP_EN
  task automatic test_wrap();
    int pulses = 0;
    step(1, 0, 4'b0000, 0);
    for (int k = 0; k < 4; k++) step(0, 1, seq[k], 0);
    for (int k = 4; k < 49; k++) begin
      step(0, 1, seq[k % 15], 0);
      if (dif.wrap_pulse === 1'b1) pulses++;
      checks++;
      if (dif.wrap_pulse !== (k % 15 == 0)) begin
        failures++;
        $display("FAIL wrap_pulse_w%0d: got=%b want=%b", k, dif.wrap_pulse, k % 15 == 0);
      end
    end
    checks++;
    if (dif.wrap_count !== 8'd3 || pulses != 3) begin
      failures++;
      $display("FAIL wrap_count: count=%0d pulses=%0d want 3 3", dif.wrap_count, pulses);
    end
  endtask
`endif

  task automatic test_random();
    int sidx = 0;
    int r;
    logic [3:0] w;
    bit v, clr, rst;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 199) == 0);
      if (r < 78) begin w = seq[sidx]; sidx = (sidx + 1) % 15; end
      else if (r < 88) w = 4'($urandom_range(1, 15));
      else if (r < 92) w = 4'b0000;
      else begin sidx = $urandom_range(0, 14); w = seq[sidx]; sidx = (sidx + 1) % 15; end
      if (!v) w = 4'($urandom_range(0, 15));
      step(rst, v, w, clr);
      checks++;
      if (dif.locked !== (md.mode == 2) || dif.err_pulse !== md.errp || dif.zero_seen !== md.zero || dif.err_count !== 16'(md.errc)) begin
        failures++;
        $display("FAIL rand_def@%0d: locked=%b err=%b zero=%b cnt=%0d want %b %b %b %0d", n,
                 dif.locked, dif.err_pulse, dif.zero_seen, dif.err_count, md.mode == 2, md.errp, md.zero, md.errc);
      end
      checks++;
      if (sif.locked !== (ms.mode == 2) || sif.err_pulse !== ms.errp || sif.zero_seen !== ms.zero || sif.err_count !== 2'(ms.errc)) begin
        failures++;
        $display("FAIL rand_small@%0d: locked=%b err=%b zero=%b cnt=%0d want %b %b %b %0d", n,
                 sif.locked, sif.err_pulse, sif.zero_seen, sif.err_count, ms.mode == 2, ms.errp, ms.zero, ms.errc);
      end
`ifdef LFSR_CHECKER_WRAP_EN
      checks++;
      if (dif.wrap_pulse !== md.wrapp || dif.wrap_count !== 8'(md.wrapc)) begin
        failures++;
        $display("FAIL rand_wrap@%0d: pulse=%b count=%0d want %b %0d", n, dif.wrap_pulse, dif.wrap_count, md.wrapp, md.wrapc);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    dif.in_valid = 0; dif.in_word = 0; dif.clear_errors = 0;
    sif.in_valid = 0; sif.in_word = 0; sif.clear_errors = 0;
    md = mreset(); ms = mreset();
    test_reset();
    test_lock();
    test_single_error();
    test_loss_relock();
    test_zero_gap();
    test_saturate_clear();
`ifdef LFSR_CHECKER_WRAP_EN
    test_wrap();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
